// File: rtl/orange_sweep_if.sv
// orange_sweep_if: handshake and result bundle for orange_sweep.
// When ORANGE_SWEEP_HOLD_EN is defined the bundle also carries the hold request.
interface orange_sweep_if #(
   parameter int N = 4
);
   logic         start;
   logic         abort;
`ifdef ORANGE_SWEEP_HOLD_EN
   logic         hold;
`endif
   logic         busy;
   logic [N-1:0] vec;
   logic         y;
   logic         z;
   logic         valid;
   logic         done;
   logic [N:0]   y_cnt;
   logic [N:0]   z_cnt;

`ifdef ORANGE_SWEEP_HOLD_EN
   modport master (output start, abort, hold,
                   input  busy, vec, y, z, valid, done, y_cnt, z_cnt);
   modport slave  (input  start, abort, hold,
                   output busy, vec, y, z, valid, done, y_cnt, z_cnt);
`else
   modport master (output start, abort,
                   input  busy, vec, y, z, valid, done, y_cnt, z_cnt);
   modport slave  (input  start, abort,
                   output busy, vec, y, z, valid, done, y_cnt, z_cnt);
`endif
endinterface

// File: rtl/orange_sweep.sv
// orange_sweep: walks every N-bit input vector once per start request and
// emits the registered y/z truth-table values for each, counting the ones.
// Optional feature macro: ORANGE_SWEEP_HOLD_EN adds a hold input that stalls
// the sweep while in RUN.
module orange_sweep #(
   parameter int                  N    = 4,
   parameter logic [(1<<N)-1:0]   Y_TT = 16'h6996,
   parameter logic [(1<<N)-1:0]   Z_TT = 16'h8000
) (
   input  logic          clk,
   input  logic          rst_n,
   orange_sweep_if.slave bus
);
   localparam logic [N-1:0] LAST = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_reg;
   logic [N-1:0] idx_reg;
   logic [N-1:0] vec_reg;
   logic         y_reg;
   logic         z_reg;
   logic         valid_reg;
   logic         done_reg;
   logic         busy_reg;
   logic [N:0]   y_cnt_reg;
   logic [N:0]   z_cnt_reg;
   logic         hold_in;

`ifdef ORANGE_SWEEP_HOLD_EN
   assign hold_in = bus.hold;
`else
   assign hold_in = 1'b0;
`endif

   // Sweep FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         vec_reg   <= '0;
         y_reg     <= 1'b0;
         z_reg     <= 1'b0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         y_cnt_reg <= '0;
         z_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg  <= 1'b0;
               valid_reg <= 1'b0;
               // abort wins over a simultaneous start
               if (bus.start && !bus.abort) begin
                  state_reg <= RUN;
                  idx_reg   <= '0;
                  y_cnt_reg <= '0;
                  z_cnt_reg <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  // counters keep their partial totals, no done pulse
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
                  busy_reg  <= 1'b0;
               end else if (hold_in) begin
                  valid_reg <= 1'b0;
               end else begin
                  vec_reg   <= idx_reg;
                  y_reg     <= Y_TT[idx_reg];
                  z_reg     <= Z_TT[idx_reg];
                  valid_reg <= 1'b1;
                  y_cnt_reg <= y_cnt_reg + {{N{1'b0}}, Y_TT[idx_reg]};
                  z_cnt_reg <= z_cnt_reg + {{N{1'b0}}, Z_TT[idx_reg]};
                  if (idx_reg == LAST) begin
                     state_reg <= DONE;
                  end else begin
                     idx_reg <= idx_reg + 1'b1;
                  end
               end
            end
            DONE: begin
               // start and abort are both ignored here
               valid_reg <= 1'b0;
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_reg;
   assign bus.vec   = vec_reg;
   assign bus.y     = y_reg;
   assign bus.z     = z_reg;
   assign bus.valid = valid_reg;
   assign bus.done  = done_reg;
   assign bus.y_cnt = y_cnt_reg;
   assign bus.z_cnt = z_cnt_reg;
endmodule

// File: tb/tb_orange_sweep.sv
// tb_orange_sweep: self-checking bench for orange_sweep. Default-parameter
// instance driven from a sweep table plus hand-written corner sequences;
// a second N=2 instance exercises hold when ORANGE_SWEEP_HOLD_EN is defined.
module tb_orange_sweep;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   orange_sweep_if #(.N(4)) b4 ();
   orange_sweep_if #(.N(2)) b2 ();

   orange_sweep #(.N(4), .Y_TT(16'h6996), .Z_TT(16'h8000)) u4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4)
   );

   orange_sweep #(.N(2), .Y_TT(4'b1110), .Z_TT(4'b0001)) u2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2)
   );

   logic [15:0] y_tt = 16'h6996;
   logic [15:0] z_tt = 16'h8000;
   logic [3:0]  y_tt2 = 4'b1110;
   logic [3:0]  z_tt2 = 4'b0001;

   typedef struct {
      logic [3:0] vec;
      logic       y;
      logic       z;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int abort_vec;     // visible vec at which abort is raised, -1 = never
      bit start_in_run;  // keep start high throughout the sweep
      bit exp_done;      // expected done pulse
   } sweep_t;

   int last_ey = 0;
   int last_ez = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every valid sample is popped and compared
   always @(negedge clk) begin
      if (rst_n && b4.valid) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_vec", {28'd0, b4.vec}, {28'd0, e.vec});
            chk("sb_y", {31'd0, b4.y}, {31'd0, e.y});
            chk("sb_z", {31'd0, b4.z}, {31'd0, e.z});
            $display("sample vec=%0d y=%0b z=%0b", b4.vec, b4.y, b4.z);
         end
      end
   end

   task automatic push_sweep();
      for (int v = 0; v < 16; v++) begin
         sb.push_back('{4'(v), y_tt[v], z_tt[v]});
      end
   endtask

   task automatic run_sweep(input sweep_t s);
      int  last;
      int  nval  = 0;
      int  ndone = 0;
      int  ey    = 0;
      int  ez    = 0;
      bit  fin   = 0;
      last = (s.abort_vec < 0) ? 15 : s.abort_vec;
      for (int v = 0; v <= last; v++) begin
         ey += int'(y_tt[v]);
         ez += int'(z_tt[v]);
      end
      b4.start = 1'b1;
      push_sweep();
      @(negedge clk);
      b4.start = s.start_in_run;
      chk("e0_busy", {31'd0, b4.busy}, 32'd1);
      chk("e0_valid", {31'd0, b4.valid}, 32'd0);
      chk("e0_ycnt", {27'd0, b4.y_cnt}, 32'd0);
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         if (b4.valid) nval++;
         if (b4.done)  ndone++;
         b4.abort = b4.valid && s.abort_vec >= 0 && int'(b4.vec) == s.abort_vec;
         if (!b4.busy) begin
            fin = 1;
            b4.start = 1'b0;
            b4.abort = 1'b0;
            chk("end_valid", {31'd0, b4.valid}, 32'd0);
         end
      end
      chk("sweep_finished", {31'd0, fin}, 32'd1);
      if (s.exp_done) chk("sb_drained", sb.size(), 32'd0);
      sb.delete();
      chk("valid_count", nval, last + 1);
      chk("done_count", ndone, {31'd0, s.exp_done});
      chk("y_cnt", {27'd0, b4.y_cnt}, ey);
      chk("z_cnt", {27'd0, b4.z_cnt}, ez);
      @(negedge clk);
      chk("post_done", {31'd0, b4.done}, 32'd0);
      chk("post_busy", {31'd0, b4.busy}, 32'd0);
      chk("post_ycnt_hold", {27'd0, b4.y_cnt}, ey);
      $display("sweep abort_vec=%0d start_in_run=%0b valid=%0d done=%0d y_cnt=%0d z_cnt=%0d",
               s.abort_vec, s.start_in_run, nval, ndone, b4.y_cnt, b4.z_cnt);
      last_ey = ey;
      last_ez = ez;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  {31'd0, b4.busy},  32'd0);
      chk({tag, "_valid"}, {31'd0, b4.valid}, 32'd0);
      chk({tag, "_done"},  {31'd0, b4.done},  32'd0);
      chk({tag, "_vec"},   {28'd0, b4.vec},   32'd0);
      chk({tag, "_y"},     {31'd0, b4.y},     32'd0);
      chk({tag, "_z"},     {31'd0, b4.z},     32'd0);
      chk({tag, "_ycnt"},  {27'd0, b4.y_cnt}, 32'd0);
      chk({tag, "_zcnt"},  {27'd0, b4.z_cnt}, 32'd0);
   endtask

   sweep_t tbl[6];

   initial begin
      bit fin;
      int nv, ndone, hleft, ey2, ez2;
      bit used;
      tbl[0] = '{-1, 1'b0, 1'b1};
      tbl[1] = '{ 5, 1'b0, 1'b0};
      tbl[2] = '{15, 1'b0, 1'b1};   // abort while in DONE is ignored
      tbl[3] = '{ 0, 1'b1, 1'b0};
      tbl[4] = '{-1, 1'b1, 1'b1};
      tbl[5] = '{10, 1'b1, 1'b0};

      rst_n = 1'b0;
      b4.start = 1'b0;
      b4.abort = 1'b0;
      b2.start = 1'b0;
      b2.abort = 1'b0;
`ifdef ORANGE_SWEEP_HOLD_EN
      b4.hold = 1'b0;
      b2.hold = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_start_busy", {31'd0, b4.busy}, 32'd0);

      for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

      // start together with abort in IDLE: nothing happens
      b4.start = 1'b1;
      b4.abort = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("sa_busy", {31'd0, b4.busy}, 32'd0);
         chk("sa_ycnt", {27'd0, b4.y_cnt}, last_ey);
         chk("sa_zcnt", {27'd0, b4.z_cnt}, last_ez);
      end
      b4.start = 1'b0;
      b4.abort = 1'b0;
      $display("start+abort in IDLE busy=%0b y_cnt=%0d", b4.busy, b4.y_cnt);

      // start held high: a new sweep begins on the IDLE edge after done
      b4.start = 1'b1;
      push_sweep();
      fin = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         if (b4.done) fin = 1;
      end
      chk("held_done_seen", {31'd0, fin}, 32'd1);
      chk("held_done_busy", {31'd0, b4.busy}, 32'd0);
      @(negedge clk);
      chk("held_restart_busy", {31'd0, b4.busy}, 32'd1);
      chk("held_restart_ycnt", {27'd0, b4.y_cnt}, 32'd0);
      b4.start = 1'b0;
      b4.abort = 1'b1;
      @(negedge clk);
      b4.abort = 1'b0;
      chk("held_abort_busy", {31'd0, b4.busy}, 32'd0);
      chk("held_abort_valid", {31'd0, b4.valid}, 32'd0);
      sb.delete();
      $display("held start restart busy=%0b", b4.busy);

      // asynchronous reset in the middle of a sweep
      b4.start = 1'b1;
      push_sweep();
      @(negedge clk);
      b4.start = 1'b0;
      fin = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         if (b4.valid && b4.vec == 4'd9) fin = 1;
      end
      chk("rst_vec9_seen", {31'd0, fin}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      sb.delete();
      @(negedge clk);
      chk("rst_no_done", {31'd0, b4.done}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_release_idle", {31'd0, b4.busy}, 32'd0);
      $display("async reset at vec=9 busy=%0b", b4.busy);
      run_sweep(tbl[0]);

      // N=2 instance, with a 3-cycle hold at vec=1 when the feature exists
      ey2 = 0;
      ez2 = 0;
      for (int v = 0; v < 4; v++) begin
         ey2 += int'(y_tt2[v]);
         ez2 += int'(z_tt2[v]);
      end
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      nv = 0;
      ndone = 0;
      hleft = 0;
      used = 0;
      fin = 0;
      for (int c = 0; c < 30 && !fin; c++) begin
         @(negedge clk);
         if (hleft > 0) begin
            chk("n2_hold_valid", {31'd0, b2.valid}, 32'd0);
            hleft--;
         end else if (b2.valid) begin
            chk("n2_vec", {30'd0, b2.vec}, nv);
            nv++;
         end
         if (b2.done) ndone++;
         if (!b2.busy) fin = 1;
`ifdef ORANGE_SWEEP_HOLD_EN
         if (b2.valid && b2.vec == 2'd1 && !used) begin
            used  = 1;
            hleft = 3;
         end
         b2.hold = (hleft > 0);
`endif
      end
      chk("n2_finished", {31'd0, fin}, 32'd1);
      chk("n2_valid_count", nv, 32'd4);
      chk("n2_done", ndone, 32'd1);
      chk("n2_ycnt", {29'd0, b2.y_cnt}, ey2);
      chk("n2_zcnt", {29'd0, b2.z_cnt}, ez2);
      $display("n2 sweep valid=%0d done=%0d y_cnt=%0d z_cnt=%0d", nv, ndone, b2.y_cnt, b2.z_cnt);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
